// File: rtl/frame_buf_pkg.sv
// Shared constants for the 160x120 RGB444 frame buffer write side:
// geometry, write-controller state encoding and the clear fill value.
package frame_buf_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int IMA_SIZE = FB_W * FB_H;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_CLEAR   = 2'd2;

    localparam logic [11:0] CLR_FILL = 12'h000;

endpackage

// File: rtl/frame_wr_ctrl_if.sv
// Bus bundle for frame_wr_ctrl: camera stream, CPU word port, buffer write
// port and status. master = the controller, slave = sources and buffer side.
interface frame_wr_ctrl_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          cam_sof;
    logic          cam_valid;
    logic [DW-1:0] cam_data;
    logic          cap_en;
    logic          clr_start;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          frame_done;
    logic          ovf;

    modport master (
        input  cam_sof, cam_valid, cam_data, cap_en, clr_start,
        input  cpu_req, cpu_addr, cpu_data,
        output cpu_ack, mem_addr, mem_data, mem_we, busy, frame_done, ovf
    );

    modport slave (
        output cam_sof, cam_valid, cam_data, cap_en, clr_start,
        output cpu_req, cpu_addr, cpu_data,
        input  cpu_ack, mem_addr, mem_data, mem_we, busy, frame_done, ovf
    );
endinterface

// File: rtl/pix_addr_cnt.sv
// Linear pixel address counter shared by capture and clear. Clear together
// with enable loads 1, so a pixel written at address 0 leaves the count at 1.
module pix_addr_cnt #(
    parameter int AW   = 15,
    parameter int LAST = 19199
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          last
);
    assign last = (cnt == AW'(LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (clr) cnt <= en ? AW'(1) : '0;
        else if (en)  cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/frame_wr_ctrl.sv
// Frame buffer write-port controller: arbitrates clear engine > camera > CPU.
// Define FRAME_WR_CPU_EN to enable the CPU port; otherwise cpu_ack stays 0.
module frame_wr_ctrl
    import frame_buf_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMA_W = FB_W,
    parameter int IMA_H = FB_H
) (
    input  logic            clk,
    input  logic            rst,
    frame_wr_ctrl_if.master bus
);
    localparam int FRAME_SZ = IMA_W * IMA_H;

    state_t        state, nxt;
    logic          clr_wr, clr_go, start, cam_wr, done, cpu_gnt;
    logic          cnt_clr, cnt_en, last;
    logic [AW-1:0] cnt;

    pix_addr_cnt #(.AW(AW), .LAST(FRAME_SZ - 1)) u_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(cnt_en), .cnt(cnt), .last(last)
    );

    always_comb begin
        clr_wr  = (state == ST_CLEAR);
        clr_go  = bus.clr_start && !clr_wr;
        // sof (re)starts a frame from IDLE when enabled, or anytime mid-capture
        start   = bus.cam_sof && !bus.clr_start &&
                  ((state == ST_IDLE && bus.cap_en) || state == ST_CAPTURE);
        cam_wr  = bus.cam_valid && (state == ST_CAPTURE || start);
        done    = (state == ST_CAPTURE) && cam_wr && !start && !clr_go && last;
        cnt_clr = clr_go || start;
        cnt_en  = clr_wr || (cam_wr && !clr_go);
        nxt     = state;
        case (state)
            ST_IDLE:    if (clr_go) nxt = ST_CLEAR; else if (start) nxt = ST_CAPTURE;
            ST_CAPTURE: if (clr_go) nxt = ST_CLEAR; else if (done) nxt = ST_IDLE;
            ST_CLEAR:   if (last) nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

`ifdef FRAME_WR_CPU_EN
    // Gated by reset so the grant reads 0 while reset is held.
    assign cpu_gnt = rst && bus.cpu_req && !clr_wr && !cam_wr;
`else
    logic cpu_unused;
    assign cpu_unused = ^{bus.cpu_req, bus.cpu_addr, bus.cpu_data};
    assign cpu_gnt    = 1'b0;
`endif
    assign bus.cpu_ack = cpu_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.mem_we     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.ovf        <= 1'b0;
        end else begin
            state          <= nxt;
            // Delayed by one so busy spans exactly the visible write cycles.
            bus.busy       <= (state != ST_IDLE);
            bus.frame_done <= done;
            bus.mem_we     <= clr_wr || cam_wr || cpu_gnt;
            if (clr_wr) begin
                bus.mem_addr <= cnt;
                bus.mem_data <= DW'(CLR_FILL);
            end else if (cam_wr) begin
                bus.mem_addr <= start ? '0 : cnt;
                bus.mem_data <= bus.cam_data;
            end else if (cpu_gnt) begin
                bus.mem_addr <= bus.cpu_addr;
                bus.mem_data <= bus.cpu_data;
            end
            if (clr_wr && bus.cam_valid)                     bus.ovf <= 1'b1;
            else if (!clr_wr && (bus.cam_sof || bus.clr_start)) bus.ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Directed bench for frame_wr_ctrl: vector table for arbitration and short
// sequences, then full clear, full capture, restart and mid-clear reset.
module tb_frame_wr_ctrl;
    import frame_buf_pkg::*;

`ifdef FRAME_WR_CPU_EN
    localparam bit CPU_EN = 1'b1;
`else
    localparam bit CPU_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_wr_ctrl_if bus ();
    frame_wr_ctrl dut (.clk(clk), .rst(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        sof, valid, cap_en, clr, req;
        logic [11:0] data;
        logic        ack, we;
        logic [14:0] addr;
        logic [11:0] wdata;
        logic        busy, ovf;
    } vec_t;

    vec_t tv[13];

    task automatic idle_inputs();
        bus.cam_sof   = 1'b0;
        bus.cam_valid = 1'b0;
        bus.clr_start = 1'b0;
        bus.cpu_req   = 1'b0;
    endtask

    initial begin
        int  nwr, bad, bbad, sent, fd, fd_last, ok;
        logic exp_we;

        //          sof valid cap clr req data     ack we addr     wdata    busy ovf
        tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0AA, 1'b0, 1'b0, 15'd0,   12'h000, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 15'd100, 12'hABC, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h011, 1'b0, 1'b1, 15'd0,   12'h011, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h022, 1'b0, 1'b1, 15'd1,   12'h022, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 15'd100, 12'hABC, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h033, 1'b0, 1'b1, 15'd2,   12'h033, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 15'd0,   12'h000, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h044, 1'b0, 1'b1, 15'd0,   12'h044, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h055, 1'b0, 1'b1, 15'd1,   12'h055, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 15'd0,   12'h000, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h7FF, 1'b0, 1'b1, 15'd0,   12'h000, 1'b1, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 15'd1,   12'h000, 1'b1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 15'd2,   12'h000, 1'b1, 1'b1};

        idle_inputs();
        bus.cam_data = '0;
        bus.cap_en   = 1'b0;
        bus.cpu_addr = 15'd100;
        bus.cpu_data = 12'hABC;
        bus.cpu_req  = 1'b1;
        #12;
        chk("reset mem_we", bus.mem_we, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset ovf", bus.ovf, 0);
        chk("reset cpu_ack", bus.cpu_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.cpu_req = 1'b0;

        // Arbitration and short sequences, ending inside a clear
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.cam_sof   = tv[i].sof;
            bus.cam_valid = tv[i].valid;
            bus.cap_en    = tv[i].cap_en;
            bus.clr_start = tv[i].clr;
            bus.cpu_req   = tv[i].req;
            bus.cam_data  = tv[i].data;
            #1 chk($sformatf("v%0d cpu_ack", i), bus.cpu_ack, tv[i].ack & CPU_EN);
            @(posedge clk);
            #1;
            exp_we = tv[i].ack ? CPU_EN : tv[i].we;
            chk($sformatf("v%0d mem_we", i), bus.mem_we, exp_we);
            if (exp_we) begin
                chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tv[i].addr);
                chk($sformatf("v%0d mem_data", i), bus.mem_data, tv[i].wdata);
            end
            chk($sformatf("v%0d busy", i), bus.busy, tv[i].busy);
            chk($sformatf("v%0d ovf", i), bus.ovf, tv[i].ovf);
            chk($sformatf("v%0d frame_done", i), bus.frame_done, 0);
        end

        // Reset asserted asynchronously while the clear writes address 5000
        @(negedge clk);
        idle_inputs();
        ok = 0;
        for (int k = 0; k < 6000 && ok == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we && bus.mem_addr == 15'd5000) ok = 1;
        end
        chk("clear reaches 5000", ok, 1);
        bus.cpu_req   = 1'b1;
        bus.cam_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst mem_we", bus.mem_we, 0);
        chk("async rst mem_addr", bus.mem_addr, 0);
        chk("async rst mem_data", bus.mem_data, 0);
        chk("async rst busy", bus.busy, 0);
        chk("async rst ovf", bus.ovf, 0);
        chk("async rst cpu_ack", bus.cpu_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("post rst mem_we", bus.mem_we, 0);
        chk("post rst busy", bus.busy, 0);
        @(negedge clk);
        bus.cpu_req = 1'b1;
        #1 chk("post rst idle grant", bus.cpu_ack, CPU_EN);
        @(posedge clk);
        #1 chk("post rst cpu write", bus.mem_we, CPU_EN);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst no clear", bus.mem_we, 0);
        chk("post rst idle busy", bus.busy, 0);

        // Full clear with camera pixels arriving mid-clear
        @(negedge clk);
        bus.clr_start = 1'b1;
        nwr = 0; bad = 0; bbad = 0; sent = 0; ok = 0;
        for (int k = 0; k < IMA_SIZE + 100 && ok == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we) begin
                if (int'(bus.mem_addr) != nwr || bus.mem_data != 12'h000) bad++;
                if (int'(bus.mem_addr) == IMA_SIZE) sent++;
                nwr++;
            end else if (nwr == IMA_SIZE) ok = 1;
            if (bus.busy != bus.mem_we) bbad++;
            @(negedge clk);
            bus.clr_start = 1'b0;
            bus.cam_valid = (k >= 100 && k < 104);
            bus.cam_data  = 12'hFFF;
        end
        chk("clear finished", ok, 1);
        chk("clear write count", nwr, IMA_SIZE);
        chk("clear addr/data seq", bad, 0);
        chk("clear busy span", bbad, 0);
        chk("clear sentinel", sent, 0);
        chk("clear ovf set", bus.ovf, 1);

        // Full capture; sof clears ovf
        bus.cam_valid = 1'b0;
        bus.cam_sof   = 1'b1;
        bus.cap_en    = 1'b1;
        @(posedge clk);
        #1;
        chk("sof clears ovf", bus.ovf, 0);
        chk("sof alone no write", bus.mem_we, 0);
        bad = 0; fd = 0; fd_last = 0;
        for (int i = 0; i < IMA_SIZE; i++) begin
            @(negedge clk);
            bus.cam_sof   = 1'b0;
            bus.cam_valid = 1'b1;
            bus.cam_data  = 12'(i % 4096);
            @(posedge clk);
            #1;
            if (!bus.mem_we || int'(bus.mem_addr) != i || int'(bus.mem_data) != i % 4096) bad++;
            if (bus.frame_done) begin
                fd++;
                if (i == IMA_SIZE - 1) fd_last = 1;
            end
        end
        @(negedge clk);
        bus.cam_valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.frame_done) fd++;
        chk("capture pixels", bad, 0);
        chk("capture done count", fd, 1);
        chk("capture done timing", fd_last, 1);
        chk("capture idle busy", bus.busy, 0);
        @(negedge clk);
        bus.cam_valid = 1'b1;
        bus.cam_data  = 12'h123;
        @(posedge clk);
        #1 chk("idle no sof no write", bus.mem_we, 0);

        // Restart after 50 pixels
        @(negedge clk);
        bus.cam_valid = 1'b0;
        bus.cam_sof   = 1'b1;
        bad = 0; fd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.cam_sof   = 1'b0;
            bus.cam_valid = 1'b1;
            bus.cam_data  = 12'h800 | 12'(i);
            @(posedge clk);
            #1;
            if (!bus.mem_we || int'(bus.mem_addr) != i) bad++;
            if (bus.frame_done) fd++;
        end
        @(negedge clk);
        bus.cam_valid = 1'b0;
        bus.cam_sof   = 1'b1;
        @(posedge clk);
        #1;
        if (bus.frame_done) fd++;
        for (int i = 0; i < IMA_SIZE; i++) begin
            @(negedge clk);
            bus.cam_sof   = 1'b0;
            bus.cam_valid = 1'b1;
            bus.cam_data  = 12'(i % 4096);
            @(posedge clk);
            #1;
            if (!bus.mem_we || int'(bus.mem_addr) != i) bad++;
            if (bus.frame_done) fd++;
        end
        @(negedge clk);
        bus.cam_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) fd++;
        end
        chk("restart addresses", bad, 0);
        chk("restart done count", fd, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_wr_ctrl.md
# frame_wr_ctrl

Write-port controller for the dual-port frame buffer (160×120 RGB444, 12-bit words, 15-bit address). It drives the buffer's single write port (address, data, write enable) and shares it among three sources: the camera pixel stream, a CPU single-word port and an internal clear engine. It sequences capture frame by frame and generates linear addresses. The read port and the VGA side are outside this block.

## Interface
- `AW`, 15: address width, matches the frame buffer.
- `DW`, 12: pixel width, RGB444.
- `IMA_W`, 160: image width in pixels.
- `IMA_H`, 120: image height in pixels.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cam_sof` in 1: start-of-frame pulse, one cycle.
- `cam_valid` in 1: pixel strobe, one cycle per pixel.
- `cam_data` in DW: pixel value, sampled when `cam_valid`=1.
- `cap_en` in 1: capture enable; level, sampled at `cam_sof`.
- `clr_start` in 1: start clear; one-cycle pulse.
- `cpu_req` in 1: CPU write request; held until `cpu_ack`.
- `cpu_addr` in AW: CPU word address.
- `cpu_data` in DW: CPU word data.
- `cpu_ack` out 1: one-cycle grant; the write is issued in that cycle.
- `mem_addr` out AW: to buffer `addr_in`.
- `mem_data` out DW: to buffer `data_in`.
- `mem_we` out 1: to buffer `regwrite`.
- `busy` out 1: high in CAPTURE or CLEAR.
- `frame_done` out 1: one-cycle pulse when a captured frame completes.
- `ovf` out 1: sticky; a pixel was dropped. Cleared by `cam_sof` or `clr_start`.

## Operation
- `IMA_SIZE` = `IMA_W`·`IMA_H` = 19200, below 2^AW. Address `IMA_SIZE` is the black sentinel word and is never written.
- States: IDLE, CAPTURE, CLEAR.
- **IDLE**
  - `clr_start` → CLEAR. It is checked first.
  - Else `cam_sof` with `cap_en`=1 → CAPTURE, pixel counter := 0.
- **CAPTURE**
  - Each `cam_valid` writes `cam_data` at the counter address, then the counter increments.
  - When the counter reaches `IMA_SIZE`, the write at `IMA_SIZE`-1 is the last one. Next cycle: `frame_done`=1, → IDLE.
  - `cam_sof` mid-frame: counter := 0 and the frame restarts. No `frame_done`.
  - `clr_start` mid-frame aborts capture → CLEAR. No `frame_done`.
- **CLEAR**
  - Writes 0 to addresses 0..`IMA_SIZE`-1, one per cycle, then → IDLE.
  - `cam_valid` during CLEAR drops the pixel and sets `ovf`.
  - `clr_start` during CLEAR is ignored.
  - `cam_sof` during CLEAR is ignored.
- **Write-port priority**, each cycle: CLEAR write > camera write > CPU write.
- **CPU grant:** `cpu_ack` is asserted only in a cycle with `cpu_req`=1, not in CLEAR, and no `cam_valid` write. CPU writes are allowed in IDLE and in CAPTURE gaps.
- The CPU may write address `IMA_SIZE` or above; no address check is made.

## Timing
- Outputs are registered. `mem_*` appear one cycle after the input (`cam_valid`, grant cycle) that causes them.
- `cpu_ack` is combinational from `cpu_req` and state. The CPU's address and data are registered with the same edge.
- Reset values: state IDLE, counter 0, `mem_addr`=0, `mem_data`=0, `mem_we`=0, `cpu_ack`=0, `busy`=0, `frame_done`=0, `ovf`=0.
- Reset mid-CLEAR or mid-CAPTURE aborts immediately. Buffer contents are not restored.
- A CLEAR takes exactly `IMA_SIZE` cycles of `mem_we`=1. `busy` falls the cycle after the last write.
- `cam_valid` and `cam_sof` in the same cycle: the restart takes effect, and the pixel is written at address 0.

## Configuration
- `FRAME_WR_CPU_EN` defined: CPU port arbitrated as above.
- `FRAME_WR_CPU_EN` undefined:
  - `cpu_ack` is tied 0 and `cpu_*` inputs are ignored.
  - The arbiter reduces to CLEAR > camera.
  - Ports remain present.

## Structure
- Package `frame_buf_pkg` holds:
  - the `IMA_SIZE` localparam;
  - the state typedef (IDLE/CAPTURE/CLEAR);
  - the CLEAR fill value 12'h000.
- Sub-module `pix_addr_cnt`: the AW-bit counter with clear, enable and terminal flag at `IMA_SIZE`-1. It is shared by CAPTURE and CLEAR.

## Test plan
- **Clear:** reset, `clr_start` pulse → 19200 writes of data 0 at addresses 0..19199 on consecutive cycles, `busy` high for exactly that span, never address 19200.
- **Capture:** `cap_en`=1, `cam_sof`, then 19200 `cam_valid` pixels with data = index mod 4096 → writes at addresses 0..19199 with matching data, then one `frame_done` pulse, state IDLE.
- **CPU vs camera:** `cpu_req` held (addr 100, data 12'hABC) while `cam_valid` is asserted on alternate cycles → `cpu_ack` only in a gap cycle, exactly one CPU write at 100, no camera pixel lost.
- **Clear drops pixels:** `clr_start`, then `cam_valid` during CLEAR → `ovf`=1, no camera write; `ovf` cleared by the next `cam_sof`.
- **Restart mid-frame:** `cam_sof` after 50 pixels, then 19200 pixels → restart at address 0, exactly one `frame_done`.
- **Reset:** reset asserted mid-CLEAR at address 5000 → all outputs at reset values asynchronously, `mem_we`=0 and state IDLE after release. Repeat with `FRAME_WR_CPU_EN` undefined → `cpu_ack` never 1.
